// File: rtl/audio_pwm_dac.sv
// Audio sink: buffers 16-bit signed samples in a small FIFO. It releases one sample
// per sample period and drives a PWM bit whose duty is reloaded only at PWM period boundaries.
module audio_pwm_dac #(
  parameter int SAMPLE_DIVIDE = 2268,
  parameter int PWM_BITS      = 10,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   input_audio,
  input  logic                          input_audio_stb,
  output logic                          input_audio_ack,
  input  logic                          clear_underrun,
  output logic                          audio_pwm,
  output logic                          audio_sd,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = $clog2(SAMPLE_DIVIDE);
  localparam logic [DW-1:0]       DIV_MAX  = DW'(SAMPLE_DIVIDE - 1);
  localparam logic [LW-1:0]       LVL_FULL = LW'(FIFO_DEPTH);
  localparam logic [PWM_BITS-1:0] PWM_MAX  = '1;
  localparam logic [PWM_BITS-1:0] DUTY_MID = {1'b1, {(PWM_BITS-1){1'b0}}};

  logic [15:0]         r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [LW-1:0]       r_level;
  logic [DW-1:0]       r_div;
  logic [15:0]         r_sample;
  logic [PWM_BITS-1:0] r_duty;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                r_pwm;
  logic                r_sd;
  logic                r_underrun;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_tick;
  logic                w_pop;
  logic [15:0]         w_sample_u;
  logic [PWM_BITS-1:0] w_duty_next;
  logic                w_unused;

  assign w_full          = (r_level == LVL_FULL);
  assign w_empty         = (r_level == '0);
  assign input_audio_ack = !w_full && !rst;
  assign w_push          = input_audio_stb && input_audio_ack;
  assign w_tick          = (r_div == DIV_MAX);
  assign w_pop           = w_tick && !w_empty;

  // Offset binary: signed full-scale negative maps to duty 0.
  assign w_sample_u  = r_sample ^ 16'h8000;
  assign w_duty_next = w_sample_u[15 -: PWM_BITS];
  assign w_unused    = ^{input_audio[31:16], w_sample_u};

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= input_audio[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_sample <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_sample <= r_mem[r_rd_ptr];
      end
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (w_pop && !w_push) r_level <= r_level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_div <= '0;
    else     r_div <= w_tick ? '0 : r_div + 1'b1;
  end

  // A new underrun event beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst)                     r_underrun <= 1'b0;
    else if (w_tick && w_empty)  r_underrun <= 1'b1;
    else if (clear_underrun)     r_underrun <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm_cnt <= '0;
      r_duty    <= DUTY_MID;
      r_pwm     <= 1'b0;
      r_sd      <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (r_pwm_cnt == PWM_MAX) r_duty <= w_duty_next;
      r_pwm     <= (r_pwm_cnt < r_duty);
      r_sd      <= 1'b1;
    end
  end

  assign audio_pwm  = r_pwm;
  assign audio_sd   = r_sd;
  assign underrun   = r_underrun;
  assign fifo_level = r_level;

endmodule

// File: tb/tb_audio_pwm_dac.sv
// Directed bench for audio_pwm_dac with small parameters (divide 64, 4-bit PWM, 4-deep FIFO).
// Edge counter e counts clk edges since the most recent reset release.
module tb_audio_pwm_dac;

  localparam int SD = 64;
  localparam int PB = 4;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] input_audio = '0;
  logic        stb = 1'b0;
  logic        ack;
  logic        clr = 1'b0;
  logic        pwm;
  logic        sd;
  logic        ur;
  logic [2:0]  level;

  int n_checks = 0;
  int n_errors = 0;
  int e = 0;
  int hi;

  logic [31:0] vec  [4] = '{32'h0000_7FFF, 32'h0000_8000, 32'h0000_0000, 32'hFFFF_8000};
  int          pexp [4] = '{15, 0, 8, 0};

  always #5 clk = ~clk;

  audio_pwm_dac #(.SAMPLE_DIVIDE(SD), .PWM_BITS(PB), .FIFO_DEPTH(FD)) dut (
    .clk             (clk),
    .rst             (rst),
    .input_audio     (input_audio),
    .input_audio_stb (stb),
    .input_audio_ack (ack),
    .clear_underrun  (clr),
    .audio_pwm       (pwm),
    .audio_sd        (sd),
    .underrun        (ur),
    .fifo_level      (level)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic run_to(input int n);
    while (e < n) step();
  endtask

  task automatic measure(output int cnt);
    cnt = 0;
    repeat (16) begin
      step();
      cnt += int'(pwm);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    stb = 1'b0;
    clr = 1'b0;
    repeat (n) step();
    chk("sd_in_rst", sd, 0);
    chk("ack_in_rst", ack, 0);
    chk("level_in_rst", level, 0);
    rst = 1'b0;
    e = 0;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, idle PWM, underrun and clear behaviour
    do_reset(3);
    chk("ack_after_rst", ack, 1);
    chk("level_after_rst", level, 0);
    chk("ur_after_rst", ur, 0);
    chk("sd_release_cycle", sd, 0);
    step();
    chk("sd_enabled", sd, 1);
    measure(hi);
    chk("pwm_mid", hi, 8);
    run_to(63);
    chk("ur_before_tick", ur, 0);
    step();
    chk("ur_first_tick", ur, 1);
    measure(hi);
    chk("pwm_hold_underrun", hi, 8);
    run_to(90);
    clr = 1'b1; step(); clr = 1'b0;
    chk("ur_cleared", ur, 0);
    run_to(127);
    clr = 1'b1; step(); clr = 1'b0;
    chk("ur_set_wins", ur, 1);
    clr = 1'b1; step(); clr = 1'b0;
    chk("ur_cleared2", ur, 0);

    // Push into empty FIFO on the tick cycle
    run_to(191);
    stb = 1'b1; input_audio = 32'h0000_4000;
    step();
    stb = 1'b0;
    chk("ur_push_on_tick", ur, 1);
    chk("level_push_on_tick", level, 1);
    run_to(256);
    chk("level_after_pop", level, 0);
    run_to(288);
    measure(hi);
    chk("pwm_4000", hi, 12);

    // Reset mid-operation with three words buffered
    stb = 1'b1;
    for (int w = 1; w <= 3; w++) begin
      input_audio = 32'(w);
      step();
    end
    stb = 1'b0;
    chk("level_three", level, 3);
    do_reset(1);
    chk("level_midrst", level, 0);
    chk("ur_midrst", ur, 0);
    chk("ack_midrst", ack, 1);
    measure(hi);
    chk("pwm_mid_midrst", hi, 8);
    run_to(63);
    chk("ur_restart_pre", ur, 0);
    step();
    chk("ur_restart_tick", ur, 1);

    // Fill to full, pop on full
    do_reset(3);
    stb = 1'b1;
    for (int w = 1; w <= 4; w++) begin
      input_audio = 32'(w);
      step();
    end
    input_audio = 32'd5;
    chk("level_full", level, 4);
    chk("ack_full", ack, 0);
    run_to(63);
    chk("level_full_hold", level, 4);
    chk("ack_full_hold", ack, 0);
    step();
    chk("level_pop_full", level, 3);
    chk("ack_after_pop", ack, 1);
    step();
    stb = 1'b0;
    chk("level_refill", level, 4);
    chk("ack_refull", ack, 0);

    // Duty mapping, including upper-bit masking and FIFO order
    do_reset(3);
    stb = 1'b1;
    for (int k = 0; k < 4; k++) begin
      input_audio = vec[k];
      step();
    end
    stb = 1'b0;
    chk("level_map_fill", level, 4);
    for (int k = 1; k <= 4; k++) begin
      run_to(SD * k + 32);
      measure(hi);
      chk($sformatf("pwm_map%0d", k), hi, pexp[k-1]);
    end
    chk("level_map_end", level, 0);
    chk("ur_map_end", ur, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
